// File: rtl/lc3_mem_model.sv
// Unified LC3 instruction/data memory with independent fetch and data channels,
// each adding a programmable, clamped number of wait states before completion.
module lc3_mem_model #(
    parameter int ADDR_W      = 16,
    parameter int T_FETCH_MAX = 10,
    parameter int T_DATA_MAX  = 10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] pc,
    input  logic        instrmem_rd,
    output logic [15:0] Instr_dout,
    output logic        complete_instr,
    input  logic        data_req,
    input  logic        Data_rd,
    input  logic [15:0] Data_addr,
    input  logic [15:0] Data_din,
    output logic [15:0] Data_dout,
    output logic        complete_data,
    input  logic [3:0]  fetch_lat,
    input  logic [3:0]  data_lat,
    input  logic        load_en,
    input  logic [15:0] load_addr,
    input  logic [15:0] load_data
);

    localparam int          DEPTH = 1 << ADDR_W;
    localparam logic [3:0]  F_MAX = 4'(T_FETCH_MAX);
    localparam logic [3:0]  D_MAX = 4'(T_DATA_MAX);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    logic [15:0] mem [DEPTH];

    function automatic logic [3:0] clamp_lat(input logic [3:0] lat, input logic [3:0] lim);
        return (lat > lim) ? lim : lat;
    endfunction

    state_t            f_state;
    logic [3:0]        f_cnt;
    logic [ADDR_W-1:0] f_addr;
    logic [3:0]        f_lat_c;

    state_t            d_state;
    logic [3:0]        d_cnt;
    logic [ADDR_W-1:0] d_addr;
    logic              d_rd;
    logic [15:0]       d_din;
    logic [3:0]        d_lat_c;

    logic              d_wr_fire;
    logic [ADDR_W-1:0] d_wr_addr;
    logic [15:0]       d_wr_data;

    assign f_lat_c = clamp_lat(fetch_lat, F_MAX);
    assign d_lat_c = clamp_lat(data_lat, D_MAX);

    // A write commits on the same edge that raises complete_data; with zero
    // wait states that is the accept edge, so the live inputs are used.
    always_comb begin
        d_wr_fire = 1'b0;
        d_wr_addr = d_addr;
        d_wr_data = d_din;
        if (!reset) begin
            if (d_state == ST_IDLE) begin
                d_wr_fire = data_req && !Data_rd && (d_lat_c == 4'd0);
                d_wr_addr = Data_addr[ADDR_W-1:0];
                d_wr_data = Data_din;
            end else if (d_state == ST_WAIT) begin
                d_wr_fire = !d_rd && (d_cnt == 4'd1);
            end
        end
    end

    // Preload is written last so it wins over a same-address data write.
    always_ff @(posedge clock) begin
        if (d_wr_fire) begin
            mem[d_wr_addr] <= d_wr_data;
        end
        if (load_en) begin
            mem[load_addr[ADDR_W-1:0]] <= load_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            f_state        <= ST_IDLE;
            f_cnt          <= 4'd0;
            f_addr         <= '0;
            complete_instr <= 1'b0;
            Instr_dout     <= 16'd0;
        end else begin
            complete_instr <= 1'b0;
            case (f_state)
                ST_IDLE: begin
                    if (instrmem_rd) begin
                        f_addr <= pc[ADDR_W-1:0];
                        f_cnt  <= f_lat_c;
                        if (f_lat_c == 4'd0) begin
                            f_state        <= ST_DONE;
                            complete_instr <= 1'b1;
                            Instr_dout     <= mem[pc[ADDR_W-1:0]];
                        end else begin
                            f_state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    f_cnt <= f_cnt - 4'd1;
                    if (f_cnt == 4'd1) begin
                        f_state        <= ST_DONE;
                        complete_instr <= 1'b1;
                        Instr_dout     <= mem[f_addr];
                    end
                end
                ST_DONE: f_state <= ST_IDLE;
                default: f_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            d_state       <= ST_IDLE;
            d_cnt         <= 4'd0;
            d_addr        <= '0;
            d_rd          <= 1'b0;
            d_din         <= 16'd0;
            complete_data <= 1'b0;
            Data_dout     <= 16'd0;
        end else begin
            complete_data <= 1'b0;
            case (d_state)
                ST_IDLE: begin
                    if (data_req) begin
                        d_addr <= Data_addr[ADDR_W-1:0];
                        d_rd   <= Data_rd;
                        d_din  <= Data_din;
                        d_cnt  <= d_lat_c;
                        if (d_lat_c == 4'd0) begin
                            d_state       <= ST_DONE;
                            complete_data <= 1'b1;
                            if (Data_rd) begin
                                Data_dout <= mem[Data_addr[ADDR_W-1:0]];
                            end
                        end else begin
                            d_state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    d_cnt <= d_cnt - 4'd1;
                    if (d_cnt == 4'd1) begin
                        d_state       <= ST_DONE;
                        complete_data <= 1'b1;
                        if (d_rd) begin
                            Data_dout <= mem[d_addr];
                        end
                    end
                end
                ST_DONE: d_state <= ST_IDLE;
                default: d_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/lc3_mem_model.md
Name: lc3_mem_model

Overview:
- Synthesizable unified instruction/data memory with programmable wait states; sits directly downstream of the LC3 core's fetch and memory-access ports.
- Serves instruction fetches and data reads/writes over independent request/complete channels sharing one word-addressed array.
- Bench preloads programs through a dedicated load port, and sets per-access latency to exercise the core's stall logic.

Parameters:
- ADDR_W, 16, address width; array depth 2**ADDR_W 16-bit words.
- T_FETCH_MAX, 10, maximum fetch wait states; larger fetch_lat values are clamped to this.
- T_DATA_MAX, 10, maximum data wait states; larger data_lat values are clamped to this.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- pc  in  16  fetch address.
- instrmem_rd  in  1  fetch request, active high.
- Instr_dout  out  16  fetched instruction, valid while complete_instr=1.
- complete_instr  out  1  one-cycle fetch completion pulse.
- data_req  in  1  data access request, active high.
- Data_rd  in  1  1=read, 0=write; sampled with the request.
- Data_addr  in  16  data address.
- Data_din  in  16  write data from core.
- Data_dout  out  16  read data, valid while complete_data=1.
- complete_data  out  1  one-cycle data completion pulse (reads and writes).
- fetch_lat  in  4  fetch wait states, sampled at request accept.
- data_lat  in  4  data wait states, sampled at request accept.
- load_en  in  1  bench preload write strobe.
- load_addr  in  16  preload address.
- load_data  in  16  preload data.

Behaviour:
- Reset: complete_instr=0, complete_data=0, Instr_dout=0, Data_dout=0; both FSMs go to IDLE. Array contents are preserved.
- Reset mid-transaction aborts the transaction. No completion is issued and no pending write is committed.
- Each channel runs its own FSM with states IDLE, WAIT, DONE.
- IDLE: if the request is 1 at a clock edge, the block latches address, rd/wr and write data, and sets cnt = min(lat, T_MAX).
  - cnt=0: go to DONE.
  - cnt>0: go to WAIT.
- WAIT: cnt decrements each cycle; at cnt=1 go to DONE. Request, address and data inputs are ignored while in WAIT.
- DONE: complete=1 for exactly one cycle.
  - Read: dout = array[latched addr].
  - Write: array[latched addr] = latched din at this edge; Data_dout holds its previous value.
  - Next state is IDLE.
  - A request still high in the following cycle starts a new transaction; the address is resampled.
- Latency: with lat=N (after clamping), complete asserts N+1 cycles after the accept edge. lat=0 gives a pulse in the cycle immediately after accept.
- Outputs are registered. Instr_dout and Data_dout hold their last completed value after complete drops.
- Request dropped during WAIT: the transaction still completes.
- Array write priority: load_en has priority over a data write to the same address in the same cycle. Both land if the addresses differ.
- Read/write collision: a fetch or data read completing in the same cycle as a write (load or data) to the same address returns the old contents (read-before-write).
- Addresses above 2**ADDR_W-1 wrap (upper bits ignored).
- load_en is honoured during reset and at any other time.

Test Plan:
- Preload 0x3000=0x1021, fetch_lat=0, instrmem_rd=1 with pc=0x3000 for one cycle -> complete_instr pulses on the next cycle with Instr_dout=0x1021.
- fetch_lat=4, single fetch at 0x3001 (preloaded 0x5020) -> complete_instr is high only in the 5th cycle after accept, with Instr_dout=0x5020; pc changed to 0x4000 during WAIT has no effect.
- fetch_lat=15 -> clamped; completion arrives exactly 11 cycles after accept.
- Data write 0xBEEF to 0x4000 (data_lat=2), then a read of 0x4000 -> write complete_data after 3 cycles; read returns Data_dout=0xBEEF. A same-cycle fetch of 0x4000 completing with the write returns the old value.
- load_en to 0x5000=0x1111 and a data write of 0x2222 to 0x5000 committing on the same edge -> a subsequent read returns 0x1111.
- reset asserted during a data write WAIT -> no complete_data; location unchanged; outputs 0; after reset, fetches return preloaded contents.
